encoder_8_to_3_scan: RTL and testbench
======================================

# encoder_8_to_3_scan

Sequential priority encoder, the return path of the 3-to-8 chip-select decoder: it accepts an 8-bit one-hot or multi-hot request vector and emits the index of every set bit, highest first, one per output handshake. It sits between request/interrupt lines and a consumer that services one index at a time. It uses the decoder's chip-select convention: it is enabled only when `cs == 3'b110`.

## Interface
- `WIDTH`, 8: request vector width; must be a power of 2, at least 2.
- `IDX_W`, `$clog2(WIDTH)` = 3: index width; derived, not overridden.
- `clk  in  1`: single clock, rising edge.
- `rst_n  in  1`: reset, asynchronous assert, active-low; deassertion synchronous to `clk` externally.
- `cs  in  3`: chip select; the block is enabled only when `cs == 3'b110`.
- `in_valid  in  1`: request vector `d` valid.
- `in_ready  out  1`: block can accept a vector.
- `d  in  WIDTH`: request vector; bit i requests index i.
- `out_valid  out  1`: `y` holds a valid index.
- `out_ready  in  1`: consumer takes `y`.
- `y  out  IDX_W`: highest set index still pending.
- `last  out  1`: `y` is the final index of the current vector.
- `cnt  out  IDX_W+1`: number of indices still pending, including the current `y`.

## Operation
- There are two states, IDLE and SCAN. State and a `pending[WIDTH-1:0]` register are the only storage.
- IDLE:
  - `in_ready=1`, `out_valid=0`.
  - Accept happens when `in_valid && in_ready && cs==3'b110`.
  - On accept with `d != 0`: `pending <= d`, go to SCAN.
  - On accept with `d == 0`: the vector is consumed and dropped, and the block stays in IDLE. No output is produced.
  - If `cs != 3'b110`, nothing is accepted and `in_ready` still reads 1. The producer keeps `in_valid` held.
- SCAN:
  - `in_ready=0`, `out_valid=1`.
  - `y` = index of the highest set bit of `pending`.
  - `cnt` = popcount(`pending`).
  - `last` = (`cnt == 1`).
- Output handshake (`out_valid && out_ready`): clear bit `y` in `pending`.
  - If `last`: go to IDLE, and `pending` becomes 0.
  - Otherwise stay in SCAN with the next lower index.
- `cs` is sampled only at acceptance. Changing `cs` during SCAN has no effect; the scan completes.
- Handshake rules:
  - While `out_valid=1` and `out_ready=0`, `y`, `last` and `cnt` are held stable.
  - `out_valid` never drops without a handshake, except under reset.
- Outputs when idle: `y`, `last` and `cnt` are 0 whenever `out_valid=0`.
- Reset values:
  - state IDLE, `pending=0`.
  - `in_ready=1`, `out_valid=0`, `y=0`, `last=0`, `cnt=0`.
- Reset mid-SCAN: outputs go to reset values immediately, without waiting for a clock edge, and all remaining indices are discarded.

## Timing
- All outputs are decoded from registered state and `pending` only. There is no combinational path from `d`, `in_valid`, `cs` or `out_ready` to any output.
- Latency: a vector accepted at rising edge k gives `out_valid=1` with its first index in the cycle after edge k.
- Throughput: one index per cycle while `out_ready=1`. A vector with n set bits occupies SCAN for n cycles minimum.
- After the handshake with `last=1` at edge m, the block is in IDLE (`in_ready=1`) after edge m. The next vector can be accepted at edge m+1, giving 1 idle cycle per vector.
- The same edge never both accepts a new vector and completes the last output.

## Structure
- Package `encoder_pkg` holds:
  - the state typedef (`ENC_IDLE`, `ENC_SCAN`);
  - the constant `CS_ENABLE = 3'b110`;
  - a default-width constant `ENC_WIDTH = 8`.
- The decoder side can reuse `CS_ENABLE` from `encoder_pkg`.
- Sub-module `prio_enc_8`: purely combinational. It maps `pending` to the highest-set index, a nonzero flag and a popcount. The top level holds the FSM, `pending` and the handshakes.

## Test plan
- Reset: hold `rst_n=0` with arbitrary inputs. Required: `in_ready=1`, `out_valid=0`, `y=0`, `last=0`, `cnt=0`.
- Multi-hot scan: `cs=3'b110`, `d=8'b1010_0100` accepted, `out_ready=1`. Required `y` sequence over the next 3 cycles:
  - 7 with `cnt=3`;
  - 5 with `cnt=2`;
  - 2 with `cnt=1` and `last=1`.
  - Then `out_valid=0`, `in_ready=1`.
- Backpressure: `d=8'h81` accepted, `out_ready=0` for 3 cycles. Required: `y=7`, `cnt=2` held stable throughout. Then with `out_ready=1`: `y=7`, then `y=0` with `last=1`.
- Chip select: `cs=3'b111`, `in_valid=1`, `d=8'hFF` for 5 cycles. Required: `out_valid` stays 0. Then `cs=3'b110`: accepted, and 8 indices follow, 7 down to 0.
- Zero vector: `d=8'h00` accepted. Required: `out_valid` stays 0 and `in_ready` stays 1. The next vector `d=8'h10` gives a single `y=4` with `last=1`.
- Async reset mid-scan: `d=8'hF0`, reset asserted after the first handshake. Required: `out_valid` falls before the next clock edge. After release, `d=8'h01` gives only `y=0`, `last=1`, with no leftover indices.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared definitions for the chip-select-gated scanning priority encoder.
// The decoder side reuses CS_ENABLE so both ends agree on the select code.
package encoder_pkg;

  typedef enum logic {
    ENC_IDLE = 1'b0,
    ENC_SCAN = 1'b1
  } enc_state_t;

  localparam logic [2:0] CS_ENABLE = 3'b110;
  localparam int         ENC_WIDTH = 8;

endpackage

// File: rtl/prio_enc_8.sv
// Combinational priority encoder: highest set index, nonzero flag and popcount.
module prio_enc_8
  import encoder_pkg::*;
#(
  parameter int WIDTH = ENC_WIDTH,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] pending,
  output logic [IDX_W-1:0] idx,
  output logic             nonzero,
  output logic [IDX_W:0]   count
);

  always_comb begin
    idx   = '0;
    count = '0;
    // Ascending loop: the last hit is the highest set bit.
    for (int i = 0; i < WIDTH; i++) begin
      if (pending[i]) begin
        idx = IDX_W'(i);
      end
      count = count + {{IDX_W{1'b0}}, pending[i]};
    end
  end

  assign nonzero = |pending;

endmodule

// File: rtl/encoder_8_to_3_scan.sv
// Accepts a multi-hot request vector and emits each set index, highest first,
// one per output handshake. Outputs depend only on state and pending.
module encoder_8_to_3_scan
  import encoder_pkg::*;
#(
  parameter int WIDTH = ENC_WIDTH,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       cs,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] y,
  output logic             last,
  output logic [IDX_W:0]   cnt
);

  enc_state_t       state_reg, state_next;
  logic [WIDTH-1:0] pending_reg, pending_next;
  logic [WIDTH-1:0] clr_mask;
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W:0]   top_cnt;
  logic             any_set;
  logic             scanning;

  prio_enc_8 #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_prio (
    .pending (pending_reg),
    .idx     (top_idx),
    .nonzero (any_set),
    .count   (top_cnt)
  );

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_clr
      assign clr_mask[gi] = (top_idx == IDX_W'(gi));
    end
  endgenerate

  assign scanning  = (state_reg == ENC_SCAN);
  assign in_ready  = ~scanning;
  assign out_valid = scanning;
  assign y         = scanning ? top_idx : '0;
  assign cnt       = scanning ? top_cnt : '0;
  assign last      = scanning && (top_cnt == (IDX_W+1)'(1));

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    case (state_reg)
      ENC_IDLE: begin
        // A zero vector is consumed but produces nothing.
        if (in_valid && cs == CS_ENABLE && d != '0) begin
          pending_next = d;
          state_next   = ENC_SCAN;
        end
      end
      ENC_SCAN: begin
        if (out_ready) begin
          pending_next = pending_reg & ~clr_mask;
          if (last || !any_set) begin
            pending_next = '0;
            state_next   = ENC_IDLE;
          end
        end
      end
      default: begin
        pending_next = '0;
        state_next   = ENC_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ENC_IDLE;
      pending_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
    end
  end

endmodule

// File: tb/tb_encoder_8_to_3_scan.sv
// Directed bench for encoder_8_to_3_scan with hand-computed expectations.
module tb_encoder_8_to_3_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] cs;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] d;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] y;
  logic       last;
  logic [3:0] cnt;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  encoder_8_to_3_scan dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs        (cs),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .last      (last),
    .cnt       (cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [2:0] ey,
                           input logic [3:0] ec, input logic el);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    check({tag, ".in_ready"},  32'(in_ready),  32'(!v));
    check({tag, ".y"},         32'(y),         32'(ey));
    check({tag, ".cnt"},       32'(cnt),       32'(ec));
    check({tag, ".last"},      32'(last),      32'(el));
    $display("%0t %s: valid=%0d y=%0d cnt=%0d last=%0d", $time, tag, out_valid, y, cnt, last);
  endtask

  initial begin
    rst_n = 1'b0; cs = 3'b110; in_valid = 1'b1; d = 8'hFF; out_ready = 1'b1;
    step(); step();
    check_out("reset", 1'b0, 3'd0, 4'd0, 1'b0);
    rst_n = 1'b1;

    // Multi-hot scan
    cs = 3'b110; in_valid = 1'b1; d = 8'b1010_0100; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check_out("mh0", 1'b1, 3'd7, 4'd3, 1'b0);
    step(); check_out("mh1", 1'b1, 3'd5, 4'd2, 1'b0);
    step(); check_out("mh2", 1'b1, 3'd2, 4'd1, 1'b1);
    step(); check_out("mh_idle", 1'b0, 3'd0, 4'd0, 1'b0);

    // Backpressure
    d = 8'h81; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_out("bp_hold", 1'b1, 3'd7, 4'd2, 1'b0);
      step();
    end
    check_out("bp_hold", 1'b1, 3'd7, 4'd2, 1'b0);
    out_ready = 1'b1;
    step(); check_out("bp1", 1'b1, 3'd0, 4'd1, 1'b1);
    step(); check_out("bp_idle", 1'b0, 3'd0, 4'd0, 1'b0);

    // Chip select gating
    cs = 3'b111; in_valid = 1'b1; d = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      step(); check_out("cs_off", 1'b0, 3'd0, 4'd0, 1'b0);
    end
    cs = 3'b110;
    step();
    in_valid = 1'b0; cs = 3'b000;
    for (int i = 7; i >= 0; i--) begin
      check_out("cs_scan", 1'b1, 3'(i), 4'(i + 1), i == 0);
      step();
    end
    check_out("cs_idle", 1'b0, 3'd0, 4'd0, 1'b0);

    // Zero vector is dropped
    cs = 3'b110; d = 8'h00; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_out("zero0", 1'b0, 3'd0, 4'd0, 1'b0);
    step(); check_out("zero1", 1'b0, 3'd0, 4'd0, 1'b0);
    d = 8'h10; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_out("single", 1'b1, 3'd4, 4'd1, 1'b1);
    step(); check_out("single_idle", 1'b0, 3'd0, 4'd0, 1'b0);

    // Asynchronous reset mid-scan
    d = 8'hF0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_out("ar0", 1'b1, 3'd7, 4'd4, 1'b0);
    step(); check_out("ar1", 1'b1, 3'd6, 4'd3, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_out("ar_async", 1'b0, 3'd0, 4'd0, 1'b0);
    #2 rst_n = 1'b1;
    step(); check_out("ar_released", 1'b0, 3'd0, 4'd0, 1'b0);
    d = 8'h01; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_out("ar_next", 1'b1, 3'd0, 4'd1, 1'b1);
    step(); check_out("ar_idle", 1'b0, 3'd0, 4'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
